// File: rtl/ccip_c1_tx_arb.sv
// ccip_c1_tx_arb: round-robin arbiter sharing one CCI-P c1 Tx (memory write)
// channel between NUM_REQ requesters. Multi-beat packets are never
// interleaved: the grant locks from the first beat to the last beat.
//
// Ports:
//   pClk, pck_cp2af_softReset_n : clock, async active-low reset
//   req_valid/req_eop           : per-requester beat valid / last beat of packet
//   req_hdr/req_data            : per-requester header/data, flat slices
//   req_ready                   : per-requester beat accepted (combinational)
//   c1_almfull                  : upstream almost-full, blocks new packets only
//   c1_valid/c1_hdr/c1_data     : registered c1 write request
//   grant_id                    : requester owning the current c1_valid beat
//   err_sticky                  : packet exceeded 4 beats; cleared by reset only
module ccip_c1_tx_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int HDR_W   = 80,
  parameter  int DATA_W  = 512,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      pClk,
  input  logic                      pck_cp2af_softReset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_eop,
  input  logic [NUM_REQ*HDR_W-1:0]  req_hdr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      c1_almfull,
  output logic                      c1_valid,
  output logic [HDR_W-1:0]          c1_hdr,
  output logic [DATA_W-1:0]         c1_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      err_sticky
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     lock_id_q, lock_id_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d;
  logic                c1_valid_q, c1_valid_d;
  logic [HDR_W-1:0]    c1_hdr_q, c1_hdr_d;
  logic [DATA_W-1:0]   c1_data_q, c1_data_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic                err_q, err_d;

  logic                found;
  logic [ID_W-1:0]     win, idx, sel_id, nxt_ptr;
  logic [NUM_REQ-1:0]  rdy;
  logic                accept, pkt_end;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A locked packet completes regardless of almfull: a <=4-line packet
  // fits in the almost-full slack, and stalling it would only hold the bus.
  always_comb begin
    rdy    = '0;
    sel_id = win;
    if (state_q == LOCKED) begin
      sel_id         = lock_id_q;
      rdy[lock_id_q] = req_valid[lock_id_q];
    end else if (found && !c1_almfull) begin
      rdy[win] = 1'b1;
    end
  end

  // Ready drops the moment reset asserts, not at the next edge.
  assign req_ready = pck_cp2af_softReset_n ? rdy : '0;
  assign accept    = |rdy;
  // A 4th beat without eop is force-terminated so the bus cannot be held.
  assign pkt_end   = accept && (req_eop[sel_id] || beat_cnt_q == 2'd3);
  assign nxt_ptr   = (sel_id == ID_W'(NUM_REQ - 1)) ? '0 : sel_id + ID_W'(1);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (accept) begin
      if (pkt_end) begin
        state_d    = IDLE;
        rr_ptr_d   = nxt_ptr;
        beat_cnt_d = '0;
        if (!req_eop[sel_id]) err_d = 1'b1;
      end else if (state_q == IDLE) begin
        state_d    = LOCKED;
        lock_id_d  = sel_id;
        beat_cnt_d = 2'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + 2'd1;
      end
    end
  end

  always_comb begin
    c1_valid_d = accept;
    c1_hdr_d   = c1_hdr_q;
    c1_data_d  = c1_data_q;
    grant_id_d = grant_id_q;
    if (accept) begin
      c1_hdr_d   = req_hdr[int'(sel_id)*HDR_W +: HDR_W];
      c1_data_d  = req_data[int'(sel_id)*DATA_W +: DATA_W];
      grant_id_d = sel_id;
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
      c1_valid_q <= 1'b0;
      c1_hdr_q   <= '0;
      c1_data_q  <= '0;
      grant_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
      c1_valid_q <= c1_valid_d;
      c1_hdr_q   <= c1_hdr_d;
      c1_data_q  <= c1_data_d;
      grant_id_q <= grant_id_d;
      err_q      <= err_d;
    end
  end

  assign c1_valid   = c1_valid_q;
  assign c1_hdr     = c1_hdr_q;
  assign c1_data    = c1_data_q;
  assign grant_id   = grant_id_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_ccip_c1_tx_arb.sv
// Randomized scoreboard bench for ccip_c1_tx_arb. Requester drivers issue
// packets of 1/2/4 (and over-long 5) beats with gaps; a reference model
// predicts ready each cycle and queues the expected c1 beat; a monitor
// process pops and compares whenever c1_valid is seen.
module tb_ccip_c1_tx_arb;
  localparam int N      = 4;
  localparam int HDR_W  = 80;
  localparam int DATA_W = 512;
  localparam int ID_W   = 2;

  logic                   pClk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N-1:0]           req_valid = '0, req_eop = '0;
  logic [N*HDR_W-1:0]     req_hdr = '0;
  logic [N*DATA_W-1:0]    req_data = '0;
  logic [N-1:0]           req_ready;
  logic                   c1_almfull = 1'b0;
  logic                   c1_valid;
  logic [HDR_W-1:0]       c1_hdr;
  logic [DATA_W-1:0]      c1_data;
  logic [ID_W-1:0]        grant_id;
  logic                   err_sticky;

  ccip_c1_tx_arb #(.NUM_REQ(N), .HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
    .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
    .req_valid(req_valid), .req_eop(req_eop), .req_hdr(req_hdr),
    .req_data(req_data), .req_ready(req_ready), .c1_almfull(c1_almfull),
    .c1_valid(c1_valid), .c1_hdr(c1_hdr), .c1_data(c1_data),
    .grant_id(grant_id), .err_sticky(err_sticky));

  always #5 pClk = ~pClk;

  typedef struct {
    logic [HDR_W-1:0]  h;
    logic [DATA_W-1:0] d;
    int                id;
  } beat_t;

  beat_t sb[$];
  int n_vec = 0, n_err = 0;

  // requester drivers
  bit                pres[N];
  int                beat[N], plen[N];
  logic [HDR_W-1:0]  cur_h[N];
  logic [DATA_W-1:0] cur_d[N];
  int                act_mask, p_start, p_alm, len_mode;

  // reference model: owner -1 means nobody holds the channel
  int m_owner, m_ptr, m_nb;
  bit m_err;

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_wide();
    logic [DATA_W-1:0] v = '0;
    for (int b = 0; b < DATA_W; b += 32) v = (v << 32) | DATA_W'($urandom);
    return v;
  endfunction

  function automatic int pick_len();
    int l;
    if (len_mode == 0) return 1;
    l = 1 << $urandom_range(2);
    if (len_mode == 2 && $urandom_range(7) == 0) l = 5;
    return l;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] e = '0;
    bit hit = 0;
    if (m_owner >= 0) e[m_owner] = req_valid[m_owner];
    else if (!c1_almfull)
      for (int k = 0; k < N; k++)
        if (!hit && req_valid[(m_ptr + k) % N]) begin
          hit = 1;
          e[(m_ptr + k) % N] = 1'b1;
        end
    return e;
  endfunction

  task automatic model_accept(input int i, input bit eop);
    if (m_owner < 0) begin
      if (eop) m_ptr = (i + 1) % N;
      else begin m_owner = i; m_nb = 1; end
    end else begin
      m_nb++;
      if (eop || m_nb == 4) begin
        if (!eop) m_err = 1;
        m_owner = -1;
        m_ptr   = (i + 1) % N;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] e;
    beat_t b;
    @(negedge pClk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i]) begin
        bit np = 0;
        if (plen[i] == 0) begin
          if (act_mask[i] && $urandom_range(99) < p_start) begin
            plen[i] = pick_len(); beat[i] = 0; np = 1;
          end
        end else if ($urandom_range(3) != 0) np = 1;
        if (np) begin
          pres[i]  = 1;
          cur_h[i] = HDR_W'(rnd_wide());
          cur_d[i] = rnd_wide();
        end
      end
      req_valid[i] = pres[i];
      req_eop[i]   = pres[i] && (beat[i] == plen[i] - 1);
      req_hdr[i*HDR_W +: HDR_W]    = cur_h[i];
      req_data[i*DATA_W +: DATA_W] = cur_d[i];
    end
    c1_almfull = ($urandom_range(99) < p_alm);
    #1;
    e = model_ready();
    chk("req_ready", DATA_W'(req_ready), DATA_W'(e));
    chk("err_sticky", DATA_W'(err_sticky), DATA_W'(m_err));
    for (int i = 0; i < N; i++)
      if (e[i]) begin
        b.h = cur_h[i]; b.d = cur_d[i]; b.id = i;
        sb.push_back(b);
        model_accept(i, req_eop[i]);
        pres[i] = 0;
        beat[i]++;
        if (beat[i] == plen[i]) plen[i] = 0;
      end
  endtask

  task automatic do_reset();
    @(negedge pClk);
    rst_n = 1'b0;
    #1;
    chk("rst_c1_valid", DATA_W'(c1_valid), '0);
    chk("rst_req_ready", DATA_W'(req_ready), '0);
    chk("rst_err", DATA_W'(err_sticky), '0);
    chk("rst_grant_id", DATA_W'(grant_id), '0);
    chk("rst_c1_hdr", DATA_W'(c1_hdr), '0);
    chk("rst_c1_data", c1_data, '0);
    for (int i = 0; i < N; i++) begin pres[i] = 0; plen[i] = 0; beat[i] = 0; end
    req_valid = '0;
    req_eop   = '0;
    m_owner = -1; m_ptr = 0; m_nb = 0; m_err = 0;
    sb.delete();
    repeat (2) @(negedge pClk);
    rst_n = 1'b1;
  endtask

  task automatic phase(input int mask, input int ps, input int pa,
                       input int lm, input int cycles);
    act_mask = mask; p_start = ps; p_alm = pa; len_mode = lm;
    repeat (cycles) step();
  endtask

  // monitor: every c1 beat must match the oldest predicted beat, one cycle later
  initial begin
    beat_t e;
    forever begin
      @(negedge pClk);
      if (rst_n) begin
        if (c1_valid === 1'b1) begin
          if (sb.size() == 0) chk("c1_valid_spurious", DATA_W'(c1_valid), '0);
          else begin
            e = sb.pop_front();
            chk("grant_id", DATA_W'(grant_id), DATA_W'(e.id));
            chk("c1_hdr", DATA_W'(c1_hdr), DATA_W'(e.h));
            chk("c1_data", c1_data, e.d);
          end
        end else if (sb.size() != 0) begin
          chk("c1_valid_missing", DATA_W'(c1_valid), DATA_W'(1));
          sb.delete();
        end
      end
    end
  end

  initial begin
    bit locked;
    do_reset();
    phase(4'b0100, 100, 0, 0, 20);   // lone requester, single lines
    phase(4'b1111, 100, 0, 0, 30);   // all busy: strict 0,1,2,3 rotation
    phase(4'b1111, 60, 20, 1, 400);  // mixed lengths, gaps, some almfull
    phase(4'b1111, 80, 60, 1, 300);  // heavy almfull
    phase(4'b1111, 60, 10, 2, 300);  // over-long packets trip the guard
    // reset while a packet is in flight
    act_mask = 4'b1111; p_start = 80; p_alm = 0; len_mode = 1;
    locked = 0;
    for (int c = 0; c < 200 && !locked; c++) begin
      step();
      locked = (m_owner >= 0) && (plen[m_owner] != 0);
    end
    chk("lock_reached", DATA_W'(locked), DATA_W'(1));
    do_reset();
    phase(4'b1111, 60, 20, 2, 200);
    phase(4'b1111, 0, 0, 1, 60);     // drain in-flight packets
    @(negedge pClk);
    #2;
    chk("sb_empty", DATA_W'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
